// File: rtl/bram_shadow_pkg.sv
// Shared types and constants for the BRAM shadow reader: FSM states,
// the default game-register offset table and the game map word indices.
package bram_shadow_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    localparam int DEFAULT_NUM_REGS = 7;

    // Entry i lives in bits [8i+7:8i]; entry 0 is the rightmost byte.
    localparam logic [8*DEFAULT_NUM_REGS-1:0] DEFAULT_OFFSETS =
        {8'h0E, 8'h0D, 8'h04, 8'h02, 8'h09, 8'h08, 8'h0F};

    localparam int GAME_STATE = 0;
    localparam int BALL_X     = 1;
    localparam int BALL_Y     = 2;
    localparam int PADDLE1_Y  = 3;
    localparam int PADDLE2_Y  = 4;
    localparam int SCORE1     = 5;
    localparam int SCORE2     = 6;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rd_tag_pipe.sv
// DEPTH-deep shift register of {valid, idx} tags that tracks which staging
// word each in-flight BRAM read belongs to; resets to all-invalid.
module rd_tag_pipe #(
    parameter int DEPTH = 2,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] in_idx,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx
);

    localparam int TAG_W = IDX_W + 1;

    logic [DEPTH-1:0][TAG_W-1:0] pipe_q, pipe_d;

    always_comb begin
        pipe_d    = pipe_q;
        pipe_d[0] = {in_valid, in_idx};
        for (int s = 1; s < DEPTH; s++) begin
            pipe_d[s] = pipe_q[s-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign {out_valid, out_idx} = pipe_q[DEPTH-1];

endmodule

// File: rtl/bram_shadow_reader.sv
// Sweeps NUM_REGS BRAM words into a staging bank and commits them to the
// shadow bank on frame_sync. SHADOW_CHANGE_FLAGS_EN adds per-word change flags.
module bram_shadow_reader
    import bram_shadow_pkg::*;
#(
    parameter int                      NUM_REGS  = 7,
    parameter int                      ADDR_W    = 16,
    parameter int                      DATA_W    = 16,
    parameter int                      RD_LAT    = 2,
    parameter logic [ADDR_W-1:0]       BASE_ADDR = ADDR_W'(16'h8000),
    parameter logic [8*NUM_REGS-1:0]   OFFSETS   = (8*NUM_REGS)'(DEFAULT_OFFSETS)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       frame_sync,
    input  logic [DATA_W-1:0]          q_b,
    output logic [ADDR_W-1:0]          addr_b,
    output logic [NUM_REGS*DATA_W-1:0] regs_out,
    output logic                       snapshot_valid,
    output logic                       busy,
`ifdef SHADOW_CHANGE_FLAGS_EN
    output logic [NUM_REGS-1:0]        changed,
`endif
    output logic                       overrun
);

    localparam int IDX_W = idx_width(NUM_REGS);

    state_e                          state_q, state_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic [ADDR_W-1:0]               addr_b_q, addr_b_d;
    logic [NUM_REGS-1:0][DATA_W-1:0] staging_q, staging_d;
    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
    logic                            snapshot_valid_q, snapshot_valid_d;
    logic                            overrun_q, overrun_d;

    logic             push_valid;
    logic             commit;
    logic             tag_valid;
    logic [IDX_W-1:0] tag_idx;
    logic [7:0]       cur_off;

    rd_tag_pipe #(
        .DEPTH (RD_LAT),
        .IDX_W (IDX_W)
    ) u_tag_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (push_valid),
        .in_idx    (idx_q),
        .out_valid (tag_valid),
        .out_idx   (tag_idx)
    );

    always_comb begin
        cur_off = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx_q == IDX_W'(i)) cur_off = OFFSETS[8*i +: 8];
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        addr_b_d   = addr_b_q;
        push_valid = 1'b0;
        commit     = 1'b0;
        overrun_d  = overrun_q;

        case (state_q)
            ST_IDLE: begin
                addr_b_d = '0;
                if (enable) begin
                    state_d = ST_SWEEP;
                    idx_d   = '0;
                end
            end
            ST_SWEEP: begin
                addr_b_d   = BASE_ADDR + ADDR_W'(cur_off);
                push_valid = 1'b1;
                idx_d      = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(NUM_REGS - 1)) begin
                    state_d = ST_DRAIN;
                    idx_d   = '0;
                end
            end
            // The last tag carries the highest index, so its exit ends the drain.
            ST_DRAIN: begin
                if (tag_valid && tag_idx == IDX_W'(NUM_REGS - 1)) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (frame_sync) begin
                    commit  = 1'b1;
                    idx_d   = '0;
                    state_d = enable ? ST_SWEEP : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (frame_sync && state_q != ST_HOLD) overrun_d = 1'b1;
        snapshot_valid_d = commit;
    end

    always_comb begin
        staging_d = staging_q;
        regs_d    = regs_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (tag_valid && tag_idx == IDX_W'(i)) staging_d[i] = q_b;
        end
        if (commit) regs_d = staging_q;
    end

`ifdef SHADOW_CHANGE_FLAGS_EN
    logic [NUM_REGS-1:0] changed_q, changed_d;

    always_comb begin
        changed_d = changed_q;
        if (commit) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                changed_d[i] = (staging_q[i] != regs_q[i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) changed_q <= '0;
        else       changed_q <= changed_d;
    end

    assign changed = changed_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            idx_q            <= '0;
            addr_b_q         <= '0;
            staging_q        <= '0;
            regs_q           <= '0;
            snapshot_valid_q <= 1'b0;
            overrun_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            idx_q            <= idx_d;
            addr_b_q         <= addr_b_d;
            staging_q        <= staging_d;
            regs_q           <= regs_d;
            snapshot_valid_q <= snapshot_valid_d;
            overrun_q        <= overrun_d;
        end
    end

    assign addr_b         = addr_b_q;
    assign regs_out       = regs_q;
    assign snapshot_valid = snapshot_valid_q;
    assign busy           = (state_q == ST_SWEEP) || (state_q == ST_DRAIN);
    assign overrun        = overrun_q;

endmodule
